// File: rtl/demux_tdm_1_4.sv
`timescale 1ns/1ps
// demux_tdm_1_4 -- 1-to-4 time-division demultiplexer with frame alignment.
//
// A serial stream of WIDTH-bit slots (qualified by EN, slot 0 marked by SYNC)
// is regrouped into four parallel lanes. Lanes 0..2 are held in shadow
// registers until slot 3 arrives; all four outputs then update together with
// a one-cycle V strobe, so a partial frame never reaches Y0..Y3.
//
// Stream qualifier: a word is consumed exactly on a rising CLK edge where
// EN=1; there is no back-pressure, and SYNC/DIN are don't-care when EN=0.
//
// Optional feature: define DEMUX_ERR_CNT_EN to add the 8-bit saturating
// ERR_CNT output counting alignment-error pulses.
module demux_tdm_1_4 #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] DIN,
  input  logic             EN,
  input  logic             SYNC,
  output logic [WIDTH-1:0] Y0,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y2,
  output logic [WIDTH-1:0] Y3,
  output logic             V,
  output logic             LOCK,
  output logic             ERR,
  output logic [1:0]       SLOT
`ifdef DEMUX_ERR_CNT_EN
  ,
  output logic [7:0]       ERR_CNT
`endif
);

  // LOCK is a direct view of this state bit, so the FSM state is observable.
  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic             v_q, v_d;
  logic             err_q, err_d;
  logic             cap0, cap1, cap2, load_y;
  logic [WIDTH-1:0] sh0_q, sh1_q, sh2_q;
  logic [WIDTH-1:0] y0_q, y1_q, y2_q, y3_q;

  // State register: FSM state, slot index and the two one-cycle strobes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= HUNT;
      slot_q  <= 2'd0;
      v_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      v_q     <= v_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: decides alignment, slot advance and which lane captures.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    v_d     = 1'b0;
    err_d   = 1'b0;
    cap0    = 1'b0;
    cap1    = 1'b0;
    cap2    = 1'b0;
    load_y  = 1'b0;
    if (EN) begin
      case (state_q)
        HUNT: begin
          // Unmarked words are dropped silently while searching for slot 0.
          if (SYNC) begin
            cap0    = 1'b1;
            slot_d  = 2'd1;
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (slot_q == 2'd0) begin
            if (SYNC) begin
              cap0   = 1'b1;
              slot_d = 2'd1;
            end else begin
              // Expected a frame start but got data: alignment lost.
              err_d   = 1'b1;
              slot_d  = 2'd0;
              state_d = HUNT;
            end
          end else if (SYNC) begin
            // Early SYNC: abandon the partial frame and restart on this word.
            err_d  = 1'b1;
            cap0   = 1'b1;
            slot_d = 2'd1;
          end else begin
            // Slot 3 + 1 wraps naturally to 0 in two bits.
            slot_d = slot_q + 2'd1;
            case (slot_q)
              2'd1:    cap1 = 1'b1;
              2'd2:    cap2 = 1'b1;
              default: begin
                load_y = 1'b1;
                v_d    = 1'b1;
              end
            endcase
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Datapath: shadow lanes collect slots 0..2; outputs update only on a full frame.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sh0_q <= '0;
      sh1_q <= '0;
      sh2_q <= '0;
      y0_q  <= '0;
      y1_q  <= '0;
      y2_q  <= '0;
      y3_q  <= '0;
    end else begin
      if (cap0) sh0_q <= DIN;
      if (cap1) sh1_q <= DIN;
      if (cap2) sh2_q <= DIN;
      if (load_y) begin
        y0_q <= sh0_q;
        y1_q <= sh1_q;
        y2_q <= sh2_q;
        y3_q <= DIN;
      end
    end
  end

  // Output logic: registered values straight to the ports, LOCK decoded from state.
  always_comb begin
    Y0   = y0_q;
    Y1   = y1_q;
    Y2   = y2_q;
    Y3   = y3_q;
    V    = v_q;
    ERR  = err_q;
    SLOT = slot_q;
    LOCK = (state_q == LOCKED);
  end

`ifdef DEMUX_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Error counter: counts every ERR pulse, sticks at 255.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_cnt_q <= 8'd0;
    end else if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign ERR_CNT = err_cnt_q;
`endif

endmodule

// File: tb/tb_demux_tdm_1_4.sv
`timescale 1ns/1ps
// tb_demux_tdm_1_4 -- directed and randomized bench for demux_tdm_1_4.
// The reference model tracks the frame as a queue of received words and
// publishes each completed frame to an expected queue for the scoreboard.
module tb_demux_tdm_1_4;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic         CLK = 1'b0;
  logic         RST_N;
  logic [W-1:0] DIN;
  logic         EN;
  logic         SYNC;
  logic [W-1:0] Y0, Y1, Y2, Y3;
  logic         V, LOCK, ERR;
  logic [1:0]   SLOT;
`ifdef DEMUX_ERR_CNT_EN
  logic [7:0]   ERR_CNT;
`endif

  always #5 CLK = ~CLK;

  demux_tdm_1_4 #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .DIN   (DIN),
    .EN    (EN),
    .SYNC  (SYNC),
    .Y0    (Y0),
    .Y1    (Y1),
    .Y2    (Y2),
    .Y3    (Y3),
    .V     (V),
    .LOCK  (LOCK),
    .ERR   (ERR),
    .SLOT  (SLOT)
`ifdef DEMUX_ERR_CNT_EN
    ,
    .ERR_CNT (ERR_CNT)
`endif
  );

  // ---------------- counters / scoreboard ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;
  int v_pulses  = 0;
  int err_pulses = 0;

  logic [4*W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  logic [W-1:0] frame_q[$];
  bit           m_locked;
  logic [W-1:0] m_y[4];
  bit           m_v;
  bit           m_err;
  int           m_err_cnt;

  task automatic model_reset();
    frame_q.delete();
    exp_q.delete();
    m_locked  = 1'b0;
    for (int i = 0; i < 4; i++) m_y[i] = '0;
    m_v       = 1'b0;
    m_err     = 1'b0;
    m_err_cnt = 0;
  endtask

  task automatic model_step(input bit en, input bit sync, input logic [W-1:0] din);
    m_v   = 1'b0;
    m_err = 1'b0;
    if (en) begin
      if (sync) begin
        if (m_locked && frame_q.size() != 0) m_err = 1'b1;
        frame_q.delete();
        frame_q.push_back(din);
        m_locked = 1'b1;
      end else if (m_locked) begin
        if (frame_q.size() == 0) begin
          m_err    = 1'b1;
          m_locked = 1'b0;
        end else begin
          frame_q.push_back(din);
          if (frame_q.size() == 4) begin
            for (int i = 0; i < 4; i++) m_y[i] = frame_q[i];
            m_v = 1'b1;
            exp_q.push_back({m_y[3], m_y[2], m_y[1], m_y[0]});
            frame_q.delete();
          end
        end
      end
    end
    if (m_err && m_err_cnt < 255) m_err_cnt++;
  endtask

  function automatic int m_slot();
    return m_locked ? frame_q.size() : 0;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [4*W-1:0] frame;
    check({tag, "_y0"}, 32'(Y0), 32'(m_y[0]));
    check({tag, "_y1"}, 32'(Y1), 32'(m_y[1]));
    check({tag, "_y2"}, 32'(Y2), 32'(m_y[2]));
    check({tag, "_y3"}, 32'(Y3), 32'(m_y[3]));
    check({tag, "_v"}, 32'(V), 32'(m_v));
    check({tag, "_err"}, 32'(ERR), 32'(m_err));
    check({tag, "_lock"}, 32'(LOCK), 32'(m_locked));
    check({tag, "_slot"}, 32'(SLOT), 32'(m_slot()));
    check({tag, "_err_v_excl"}, 32'(ERR & V), 32'd0);
`ifdef DEMUX_ERR_CNT_EN
    check({tag, "_err_cnt"}, 32'(ERR_CNT), 32'(m_err_cnt));
`endif
    if (V === 1'b1) v_pulses++;
    if (ERR === 1'b1) err_pulses++;
    if (V === 1'b1) begin
      check({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        frame = exp_q.pop_front();
        check({tag, "_sb_frame"}, {Y3, Y2, Y1, Y0}, frame);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit en, input bit sync, input logic [W-1:0] din, input string tag);
    EN   = en;
    SYNC = sync;
    DIN  = din;
    @(posedge CLK);
    model_step(en, sync, din);
    #1;
    check_all(tag);
  endtask

  task automatic gap(input int n, input string tag);
    for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom), W'($urandom), tag);
  endtask

  // Watchdog: the stimulus only waits on free-running clock edges, but
  // guard against a runaway anyway.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int v_before;
    int e_before;
    bit s;

    RST_N = 1'b0;
    EN    = 1'b0;
    SYNC  = 1'b0;
    DIN   = '0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge CLK);
    RST_N = 1'b1;

    // Back-to-back frame 11,22,33,44.
    drive(1'b1, 1'b1, 8'h11, "f1_s0");
    check("f1_s0_lock", 32'(LOCK), 32'd1);
    check("f1_s0_slot", 32'(SLOT), 32'd1);
    drive(1'b1, 1'b0, 8'h22, "f1_s1");
    drive(1'b1, 1'b0, 8'h33, "f1_s2");
    check("f1_s2_v", 32'(V), 32'd0);
    drive(1'b1, 1'b0, 8'h44, "f1_s3");
    check("f1_y", {Y3, Y2, Y1, Y0}, 32'h44332211);
    check("f1_v", 32'(V), 32'd1);
    check("f1_lock", 32'(LOCK), 32'd1);
    check("f1_slot_wrap", 32'(SLOT), 32'd0);
    drive(1'b0, 1'b0, 8'h00, "f1_after");
    check("f1_v_one_cycle", 32'(V), 32'd0);

    // Same frame with 3-cycle EN=0 gaps between slots.
    v_before = v_pulses;
    drive(1'b1, 1'b1, 8'h11, "f2_s0");
    gap(3, "f2_g0");
    check("f2_slot_hold0", 32'(SLOT), 32'd1);
    drive(1'b1, 1'b0, 8'h22, "f2_s1");
    gap(3, "f2_g1");
    check("f2_slot_hold1", 32'(SLOT), 32'd2);
    drive(1'b1, 1'b0, 8'h33, "f2_s2");
    gap(3, "f2_g2");
    check("f2_slot_hold2", 32'(SLOT), 32'd3);
    drive(1'b1, 1'b0, 8'h44, "f2_s3");
    check("f2_y", {Y3, Y2, Y1, Y0}, 32'h44332211);
    gap(3, "f2_g3");
    check("f2_v_once", 32'(v_pulses - v_before), 32'd1);

    // Early SYNC at slot 2 restarts the frame with A0.
    drive(1'b1, 1'b1, 8'h55, "f3_s0");
    drive(1'b1, 1'b0, 8'h66, "f3_s1");
    check("f3_slot2", 32'(SLOT), 32'd2);
    drive(1'b1, 1'b1, 8'hA0, "f3_resync");
    check("f3_err", 32'(ERR), 32'd1);
    check("f3_y_unchanged", {Y3, Y2, Y1, Y0}, 32'h44332211);
    check("f3_lock_kept", 32'(LOCK), 32'd1);
    check("f3_slot1", 32'(SLOT), 32'd1);
    drive(1'b1, 1'b0, 8'hA1, "f3_a1");
    check("f3_err_one_cycle", 32'(ERR), 32'd0);
    drive(1'b1, 1'b0, 8'hA2, "f3_a2");
    drive(1'b1, 1'b0, 8'hA3, "f3_a3");
    check("f3_y", {Y3, Y2, Y1, Y0}, 32'hA3A2A1A0);
    check("f3_v", 32'(V), 32'd1);

    // Missing SYNC at slot 0 drops lock; unmarked words then ignored.
    e_before = err_pulses;
    drive(1'b1, 1'b0, 8'h5A, "f4_nosync");
    check("f4_err", 32'(ERR), 32'd1);
    check("f4_lock", 32'(LOCK), 32'd0);
    drive(1'b1, 1'b0, 8'h5B, "f4_ign0");
    drive(1'b1, 1'b0, 8'h5C, "f4_ign1");
    check("f4_slot", 32'(SLOT), 32'd0);
    check("f4_err_once", 32'(err_pulses - e_before), 32'd1);
    check("f4_y_held", {Y3, Y2, Y1, Y0}, 32'hA3A2A1A0);

    // Asynchronous reset between edges after slot 2.
    drive(1'b1, 1'b1, 8'h12, "f5_s0");
    drive(1'b1, 1'b0, 8'h34, "f5_s1");
    drive(1'b1, 1'b0, 8'h56, "f5_s2");
    #3;
    RST_N = 1'b0;
    model_reset();
    #1;
    check("rst_async_y", {Y3, Y2, Y1, Y0}, 32'h0);
    check("rst_async_v", 32'(V), 32'd0);
    check("rst_async_err", 32'(ERR), 32'd0);
    check("rst_async_lock", 32'(LOCK), 32'd0);
    check("rst_async_slot", 32'(SLOT), 32'd0);
    check_all("rst_async");
    #2;
    RST_N = 1'b1;
    drive(1'b1, 1'b0, 8'h78, "f5_post0");
    check("f5_post_lock", 32'(LOCK), 32'd0);
    drive(1'b1, 1'b0, 8'h9A, "f5_post1");
    drive(1'b1, 1'b1, 8'hC0, "f6_s0");
    drive(1'b1, 1'b0, 8'hC1, "f6_s1");
    drive(1'b1, 1'b0, 8'hC2, "f6_s2");
    drive(1'b1, 1'b0, 8'hC3, "f6_s3");
    check("f6_y", {Y3, Y2, Y1, Y0}, 32'hC3C2C1C0);

    // Randomized stream: mostly well-formed frames with random gaps and sync faults.
    for (int i = 0; i < 400; i++) begin
      s = (m_slot() == 0) ^ ($urandom_range(0, 9) == 0);
      drive($urandom_range(0, 3) != 0, s, W'($urandom), "rnd");
    end

`ifdef DEMUX_ERR_CNT_EN
    // Error burst: repeated SYNC while mid-frame errs every cycle.
    drive(1'b1, 1'b1, W'($urandom), "cnt_lock");
    for (int i = 0; i < 300; i++) drive(1'b1, 1'b1, W'($urandom), "cnt_burst");
    check("err_cnt_saturated", 32'(ERR_CNT), 32'd255);
`endif

    drive(1'b0, 1'b0, 8'h00, "final");
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/demux_tdm_1_4.md
DEMUX_TDM_1_4 -- requirements
Module: demux_tdm_1_4

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the lane data width in bits.
REQ-002 The module SHALL have port CLK, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port RST_N, input, 1 bit, the reset; reset is asynchronous and active-low.
REQ-004 The module SHALL have port DIN, input, WIDTH bits, the time-multiplexed data word.
REQ-005 The module SHALL have port EN, input, 1 bit, which qualifies DIN as one slot in the current cycle.
REQ-006 The module SHALL have port SYNC, input, 1 bit, which marks slot 0 and is meaningful only when EN=1.
REQ-007 The module SHALL have ports Y0, Y1, Y2, Y3, output, WIDTH bits each, the demultiplexed lane words of the last complete frame.
REQ-008 The module SHALL have port V, output, 1 bit, a one-cycle frame-valid strobe.
REQ-009 The module SHALL have port LOCK, output, 1 bit, which is high while the frame is aligned.
REQ-010 The module SHALL have port ERR, output, 1 bit, a one-cycle alignment-error strobe.
REQ-011 The module SHALL have port SLOT, output, 2 bits, the index of the next expected slot.

Function
REQ-012 The FSM SHALL have two states: HUNT (LOCK=0) and LOCKED (LOCK=1).
REQ-013 In HUNT, an EN=1, SYNC=0 cycle SHALL be discarded; SLOT stays 0 and ERR stays 0.
REQ-014 In HUNT, an EN=1, SYNC=1 cycle SHALL capture DIN into shadow lane 0, set SLOT=1 and enter LOCKED.
REQ-015 In LOCKED, each EN=1, SYNC=0 cycle with SLOT in 1..3 SHALL capture DIN into shadow lane SLOT and increment SLOT modulo 4.
REQ-016 On capture of slot 3, Y0..Y2 SHALL load from shadow lanes 0..2 and Y3 from DIN at that same edge, V SHALL be 1 for exactly the following cycle, and SLOT SHALL wrap to 0.
REQ-017 Latency SHALL be 1 clock: Y and V change at the rising edge that samples the slot-3 word.
REQ-018 Y0..Y3 SHALL hold their values between frames; partial frames SHALL never reach Y.
REQ-019 In LOCKED with SLOT=0, an EN=1, SYNC=1 cycle SHALL capture slot 0 and set SLOT=1.
REQ-020 In LOCKED with SLOT=0, an EN=1, SYNC=0 cycle SHALL pulse ERR, discard the word, and enter HUNT.
REQ-021 In LOCKED with SLOT in 1..3, an EN=1, SYNC=1 cycle SHALL pulse ERR, drop the partial frame, capture DIN as slot 0, and set SLOT=1 while staying LOCKED.
REQ-022 EN=0 cycles SHALL change no state; gaps between slots SHALL be allowed, and SYNC SHALL be ignored when EN=0.
REQ-023 ERR and V SHALL never be high in the same cycle, since error cases never complete a frame.

Reset
REQ-024 When RST_N=0, the module SHALL immediately, without waiting for a clock edge, clear Y0..Y3, the shadow lanes, V, ERR and SLOT to 0 and force HUNT (LOCK=0).
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; after release, the first accepted word SHALL be an EN=1, SYNC=1 cycle.

Configuration
REQ-026 When macro DEMUX_ERR_CNT_EN is defined, the module SHALL add output ERR_CNT, 8 bits, which increments on every ERR pulse, saturates at 255, and is cleared by reset.
REQ-027 When DEMUX_ERR_CNT_EN is not defined, the ERR_CNT port and its counter SHALL be absent, with all other behaviour unchanged.

Verification
REQ-028 The bench SHALL apply reset, then EN=1 words 8'h11 (SYNC=1), 8'h22, 8'h33, 8'h44 on consecutive cycles, and SHALL check Y0..Y3=11,22,33,44, V=1 for one cycle after the 4th edge, and LOCK=1.
REQ-029 The bench SHALL repeat REQ-028 with EN=0 gaps of 3 cycles between slots and SHALL check the same Y values, V exactly once, and SLOT advancing only on EN=1.
REQ-030 The bench SHALL, when LOCKED after one frame, send SYNC=1 at SLOT=2 with DIN=8'hA0 followed by 8'hA1, 8'hA2, 8'hA3, and SHALL check one ERR pulse, Y unchanged at the error, then Y=A0,A1,A2,A3 with V=1.
REQ-031 The bench SHALL, when LOCKED at SLOT=0, send EN=1, SYNC=0, and SHALL check ERR=1 for one cycle, LOCK=0, and following SYNC=0 words ignored.
REQ-032 The bench SHALL drive RST_N low asynchronously between clock edges after slot 2 and SHALL check that all outputs are 0 and LOCK=0 before the next edge.
REQ-033 The bench SHALL, with DEMUX_ERR_CNT_EN defined, force 300 errors and SHALL check ERR_CNT=255.
